// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
//   Round-robin readout arbiter that shares one GPIO data-return path between
//   two event FIFOs (ch0, ch1). A granted channel is read for a bounded burst
//   using one-cycle read strobes. Each word is held in DATA_out until the host
//   toggles ACK_in.
//
// Ports
//   sys_clk                 system clock, rising edge
//   RESET_in                asynchronous, active-high reset
//   ENABLE_in               arbitration allowed while high (checked at burst end)
//   BURST_LEN_in[7:0]       max words per grant, 0 means 256
//   ACK_in                  host ack toggle, any change consumes one word
//   CLR_in                  synchronous clear of OVF_out and WORDS_out
//   DATA0_in/DATA1_in       FIFO read data, valid one cycle after the strobe
//   CNT0_in/CNT1_in         FIFO word counts
//   FULL0_in/FULL1_in       FIFO full flags
//   RD0_out/RD1_out         one-cycle FIFO read strobes
//   DATA_out/CH_out/LAST_out  held word, its channel, end-of-burst marker
//   VALID_out               DATA_out holds an unacknowledged word
//   BUSY_out                FSM not idle
//   OVF_out[1:0]            sticky full flags {ch1,ch0}
//   WORDS_out[31:0]         words acknowledged, wraps
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for ENABLE_in and a nonempty FIFO
// S_ARB      | pick channel, load burst down-counter
// S_READ     | read strobe to granted FIFO for this single cycle
// S_CAPTURE  | register returned word into the output holding register
// S_WAIT_ACK | word presented, waiting for the host ack toggle

module fifo_read_arbiter #(
  parameter int CNT_W  = 16,   // must be >= 9 so a count can be compared to 256
  parameter int DATA_W = 32
) (
  input  logic              sys_clk,
  input  logic              RESET_in,
  input  logic              ENABLE_in,
  input  logic [7:0]        BURST_LEN_in,
  input  logic              ACK_in,
  input  logic              CLR_in,
  input  logic [DATA_W-1:0] DATA0_in,
  input  logic [DATA_W-1:0] DATA1_in,
  input  logic [CNT_W-1:0]  CNT0_in,
  input  logic [CNT_W-1:0]  CNT1_in,
  input  logic              FULL0_in,
  input  logic              FULL1_in,
  output logic              RD0_out,
  output logic              RD1_out,
  output logic [DATA_W-1:0] DATA_out,
  output logic              VALID_out,
  output logic              CH_out,
  output logic              LAST_out,
  output logic              BUSY_out,
  output logic [1:0]        OVF_out,
  output logic [31:0]       WORDS_out
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARB      = 3'd1;
  localparam logic [2:0] S_READ     = 3'd2;
  localparam logic [2:0] S_CAPTURE  = 3'd3;
  localparam logic [2:0] S_WAIT_ACK = 3'd4;

  logic [2:0]        state;
  logic              grant;
  logic              last_grant;
  logic [8:0]        remaining;
  logic              ack_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ch_q;
  logic              last_q;
  logic [1:0]        ovf_q;
  logic [31:0]       words_q;

  logic              ne0;
  logic              ne1;
  logic              arb_pick;
  logic [8:0]        burst_words;
  logic [CNT_W-1:0]  burst_ext;
  logic [CNT_W-1:0]  cnt_pick;
  logic [8:0]        first_len;
  logic              grant_cnt_nz;
  logic              ack_evt;

  assign ne0 = |CNT0_in;
  assign ne1 = |CNT1_in;

  // With both FIFOs pending, alternate away from the last grant; otherwise
  // take whichever is nonempty (ne1 alone selects ch1, ne0 alone selects ch0).
  assign arb_pick     = (ne0 && ne1) ? ~last_grant : ne1;
  assign burst_words  = (BURST_LEN_in == 8'd0) ? 9'd256 : {1'b0, BURST_LEN_in};
  assign burst_ext    = CNT_W'(burst_words);
  assign cnt_pick     = arb_pick ? CNT1_in : CNT0_in;
  assign first_len    = (cnt_pick < burst_ext) ? cnt_pick[8:0] : burst_words;
  assign grant_cnt_nz = grant ? ne1 : ne0;
  assign ack_evt      = ACK_in ^ ack_q;

  // Strobes decode straight from state so an async reset drops them at once.
  assign RD0_out   = (state == S_READ) && !grant;
  assign RD1_out   = (state == S_READ) &&  grant;
  assign BUSY_out  = (state != S_IDLE);
  assign DATA_out  = data_q;
  assign VALID_out = valid_q;
  assign CH_out    = ch_q;
  assign LAST_out  = last_q;
  assign OVF_out   = ovf_q;
  assign WORDS_out = words_q;

  // ack_q follows ACK_in every cycle; WAIT_ACK is at least four cycles away
  // from reset release, so the reset value can never produce a false ack.
  always_ff @(posedge sys_clk or posedge RESET_in) begin
    if (RESET_in) ack_q <= 1'b0;
    else          ack_q <= ACK_in;
  end

  always_ff @(posedge sys_clk or posedge RESET_in) begin
    if (RESET_in) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      remaining  <= 9'd0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ch_q       <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ENABLE_in && (ne0 || ne1)) state <= S_ARB;
        end
        S_ARB: begin
          if (ne0 || ne1) begin
            grant      <= arb_pick;
            last_grant <= arb_pick;
            remaining  <= first_len;
            state      <= S_READ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_READ: begin
          remaining <= remaining - 9'd1;
          state     <= S_CAPTURE;
        end
        S_CAPTURE: begin
          data_q  <= grant ? DATA1_in : DATA0_in;
          ch_q    <= grant;
          last_q  <= (remaining == 9'd0);
          valid_q <= 1'b1;
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (ack_evt) begin
            valid_q <= 1'b0;
            // A FIFO that drained early ends the burst without a LAST word.
            if ((remaining != 9'd0) && grant_cnt_nz) state <= S_READ;
            else if (ENABLE_in)                      state <= S_ARB;
            else                                     state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Set has priority over clear so a full pulse coincident with CLR_in is kept.
  always_ff @(posedge sys_clk or posedge RESET_in) begin
    if (RESET_in) ovf_q <= 2'b00;
    else          ovf_q <= (CLR_in ? 2'b00 : ovf_q) | {FULL1_in, FULL0_in};
  end

  always_ff @(posedge sys_clk or posedge RESET_in) begin
    if (RESET_in)                             words_q <= 32'd0;
    else if (CLR_in)                          words_q <= 32'd0;
    else if ((state == S_WAIT_ACK) && ack_evt) words_q <= words_q + 32'd1;
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
module tb_fifo_read_arbiter;

  logic        sys_clk = 1'b0;
  logic        RESET_in = 1'b1;
  logic        ENABLE_in = 1'b0;
  logic [7:0]  BURST_LEN_in = 8'd8;
  logic        ACK_in = 1'b1;
  logic        CLR_in = 1'b0;
  logic [31:0] DATA0_in = '0;
  logic [31:0] DATA1_in = '0;
  logic [15:0] CNT0_in = '0;
  logic [15:0] CNT1_in = '0;
  logic        FULL0_in = 1'b0;
  logic        FULL1_in = 1'b0;
  logic        RD0_out, RD1_out, VALID_out, CH_out, LAST_out, BUSY_out;
  logic [31:0] DATA_out, WORDS_out;
  logic [1:0]  OVF_out;

  fifo_read_arbiter #(.CNT_W(16), .DATA_W(32)) dut (
    .sys_clk(sys_clk), .RESET_in(RESET_in), .ENABLE_in(ENABLE_in),
    .BURST_LEN_in(BURST_LEN_in), .ACK_in(ACK_in), .CLR_in(CLR_in),
    .DATA0_in(DATA0_in), .DATA1_in(DATA1_in), .CNT0_in(CNT0_in), .CNT1_in(CNT1_in),
    .FULL0_in(FULL0_in), .FULL1_in(FULL1_in), .RD0_out(RD0_out), .RD1_out(RD1_out),
    .DATA_out(DATA_out), .VALID_out(VALID_out), .CH_out(CH_out), .LAST_out(LAST_out),
    .BUSY_out(BUSY_out), .OVF_out(OVF_out), .WORDS_out(WORDS_out)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        ch;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] q0[$], q1[$];    // FIFO contents seen by the DUT
  logic [31:0] mq0[$], mq1[$];  // reference copy consumed by the model
  logic        m_last = 1'b1;
  int          n_chk = 0, n_pass = 0;
  int          nrd0 = 0, nrd1 = 0, overlap = 0;
  int          exp_rd0 = 0, exp_rd1 = 0, exp_words = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // FIFO model: pop on a strobe so data is stable for the capture cycle.
  always @(negedge sys_clk) begin
    if (RD0_out && RD1_out) overlap++;
    if (RD0_out) begin
      nrd0++;
      if (q0.size() > 0) DATA0_in = q0.pop_front();
    end
    if (RD1_out) begin
      nrd1++;
      if (q1.size() > 0) DATA1_in = q1.pop_front();
    end
    CNT0_in = 16'(q0.size());
    CNT1_in = 16'(q1.size());
  end

  task automatic push(input logic ch, input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      if (ch) begin q1.push_back(d); mq1.push_back(d); end
      else    begin q0.push_back(d); mq0.push_back(d); end
    end
  endtask

  // Reference round-robin: computes the delivered word order for nb bursts.
  task automatic model_bursts(input int nb, input int blen);
    logic g;
    int   n, cnt;
    exp_t e;
    for (int b = 0; b < nb && (mq0.size() > 0 || mq1.size() > 0); b++) begin
      if (mq0.size() > 0 && mq1.size() > 0) g = ~m_last;
      else                                  g = (mq1.size() > 0);
      m_last = g;
      cnt = g ? mq1.size() : mq0.size();
      n = (blen == 0) ? 256 : blen;
      if (cnt < n) n = cnt;
      for (int k = 0; k < n; k++) begin
        e.ch   = g;
        e.data = g ? mq1.pop_front() : mq0.pop_front();
        e.last = (k == n - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain(input int nwords, input int drop_after);
    exp_t e;
    int   t;
    for (int i = 0; i < nwords; i++) begin
      t = 0;
      while (!VALID_out && t < 60) begin @(negedge sys_clk); t++; end
      if (!VALID_out) begin chk("valid_timeout", 0, 1); return; end
      if (sb.size() == 0) begin chk("sb_underrun", 0, 1); return; end
      e = sb.pop_front();
      chk("ch", CH_out, e.ch);
      chk("data", DATA_out, e.data);
      chk("last", LAST_out, e.last);
      if (e.ch) exp_rd1++; else exp_rd0++;
      exp_words++;
      ACK_in = ~ACK_in;
      if (i + 1 == drop_after) ENABLE_in = 1'b0;
      @(negedge sys_clk);
      chk("valid_fall", VALID_out, 0);
    end
  endtask

  task automatic settle_check(input string tag);
    repeat (6) @(negedge sys_clk);
    chk({tag, "_busy"}, BUSY_out, 0);
    chk({tag, "_words"}, WORDS_out, exp_words);
    chk({tag, "_rd0"}, nrd0, exp_rd0);
    chk({tag, "_rd1"}, nrd1, exp_rd1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  int snap0, snap1;

  initial begin
    // Reset state, with ACK_in already high so the release cannot fake an ack.
    repeat (2) @(negedge sys_clk);
    chk("rst_ctl", {RD0_out, RD1_out, VALID_out, CH_out, LAST_out, BUSY_out, OVF_out}, 8'h00);
    chk("rst_data", DATA_out, 0);
    chk("rst_words", WORDS_out, 0);
    RESET_in = 1'b0;

    // Ack toggles while idle must be ignored.
    repeat (2) @(negedge sys_clk);
    ACK_in = ~ACK_in; @(negedge sys_clk);
    ACK_in = ~ACK_in; repeat (3) @(negedge sys_clk);
    chk("idle_ack_words", WORDS_out, 0);
    chk("idle_busy", BUSY_out, 0);

    // Single channel, with first-word latency.
    BURST_LEN_in = 8'd8;
    push(1'b0, 3);
    model_bursts(10, 8);
    @(negedge sys_clk);
    ENABLE_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("lat_not_yet", VALID_out, 0);
    @(negedge sys_clk);
    chk("lat_valid", VALID_out, 1);
    drain(3, 0);
    settle_check("single");

    // Round-robin 10/10, bursts of 4.
    BURST_LEN_in = 8'd4;
    ENABLE_in = 1'b0;
    push(1'b0, 10);
    push(1'b1, 10);
    model_bursts(10, 4);
    @(negedge sys_clk);
    ENABLE_in = 1'b1;
    drain(20, 0);
    settle_check("rr");

    // BURST_LEN 0 means 256.
    BURST_LEN_in = 8'd0;
    ENABLE_in = 1'b0;
    push(1'b0, 300);
    model_bursts(10, 0);
    @(negedge sys_clk);
    ENABLE_in = 1'b1;
    drain(300, 0);
    settle_check("b256");

    // Enable dropped during a burst of 4: burst finishes, no new grant.
    BURST_LEN_in = 8'd4;
    ENABLE_in = 1'b0;
    push(1'b0, 4);
    push(1'b1, 4);
    model_bursts(1, 4);
    @(negedge sys_clk);
    ENABLE_in = 1'b1;
    drain(4, 1);
    settle_check("en_drop");
    ENABLE_in = 1'b1;
    model_bursts(1, 4);
    drain(4, 0);
    settle_check("en_resume");

    // FULL1 pulse with CLR in the same cycle: set wins, counter cleared.
    chk("pre_clr_words", WORDS_out, exp_words);
    FULL1_in = 1'b1; CLR_in = 1'b1;
    @(negedge sys_clk);
    FULL1_in = 1'b0; CLR_in = 1'b0;
    exp_words = 0;
    chk("ovf_set_wins", OVF_out, 2'b10);
    chk("clr_words", WORDS_out, 0);
    FULL0_in = 1'b1;
    @(negedge sys_clk);
    FULL0_in = 1'b0;
    @(negedge sys_clk);
    chk("ovf_both", OVF_out, 2'b11);

    // Async reset while waiting for an ack.
    ENABLE_in = 1'b0;
    push(1'b0, 2);
    @(negedge sys_clk);
    ENABLE_in = 1'b1;
    begin
      int t = 0;
      while (!VALID_out && t < 60) begin @(negedge sys_clk); t++; end
    end
    chk("rst_mid_valid_pre", VALID_out, 1);
    RESET_in = 1'b1; ENABLE_in = 1'b0;
    #1;
    chk("rst_mid_ctl", {RD0_out, RD1_out, VALID_out, CH_out, LAST_out, BUSY_out, OVF_out}, 8'h00);
    chk("rst_mid_data", DATA_out, 0);
    chk("rst_mid_words", WORDS_out, 0);
    snap0 = nrd0; snap1 = nrd1;
    @(negedge sys_clk);
    RESET_in = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("rst_no_reads", nrd0 + nrd1, snap0 + snap1);
    chk("rst_idle", BUSY_out, 0);
    q0.delete(); mq0.delete();

    chk("rd_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Round-robin readout arbiter that shares the single GPIO data-return path between two event FIFOs (ch0, ch1). It grants one channel at a time for a bounded burst, issues one-cycle FIFO read strobes, and holds each word in an output register until the host acknowledges it with a toggle handshake. It sits between the FIFO bank and the GPIO controller's data mux, replacing direct host-driven read strobes. Sticky overflow flags and a delivered-word counter are provided for host status reads.

## Interface
- CNT_W, 16, width of FIFO word-count inputs
- DATA_W, 32, FIFO/output data width
- sys_clk  in  1  system clock; all logic on rising edge
- RESET_in  in  1  asynchronous, active-high reset
- ENABLE_in  in  1  level; arbitration allowed while high
- BURST_LEN_in  in  8  max words per grant; 0 means 256
- ACK_in  in  1  host ack toggle; any change = one word consumed
- CLR_in  in  1  synchronous clear of overflow flags and word counter
- DATA0_in / DATA1_in  in  DATA_W  FIFO read data, valid 1 cycle after strobe
- CNT0_in / CNT1_in  in  CNT_W  FIFO word counts
- FULL0_in / FULL1_in  in  1  FIFO full
- RD0_out / RD1_out  out  1  one-cycle FIFO read strobes
- DATA_out  out  DATA_W  held word for host
- VALID_out  out  1  DATA_out holds an unacknowledged word
- CH_out  out  1  channel of DATA_out
- LAST_out  out  1  DATA_out is final word of its burst
- BUSY_out  out  1  state != IDLE
- OVF_out  out  2  sticky full flags {ch1,ch0}
- WORDS_out  out  32  total words acknowledged, wraps modulo 2^32

## Operation
- States: IDLE, ARB, READ, CAPTURE, WAIT_ACK.
- IDLE: if ENABLE_in and (CNT0_in!=0 or CNT1_in!=0) -> ARB.
- ARB: grant rule: both nonempty -> channel != last_grant; one nonempty -> that one; none -> IDLE. Latch grant, last_grant <= grant, remaining <= min(CNT_grant, burst), burst = BURST_LEN_in or 256 if 0. -> READ.
- READ: RD_grant_out = 1 for exactly this cycle; remaining decrements. -> CAPTURE.
- CAPTURE: DATA_out <= DATA_grant_in, CH_out <= grant, LAST_out <= (remaining==0), VALID_out <= 1. -> WAIT_ACK.
- WAIT_ACK: ack event = ACK_in != ack_q (ack_q registers ACK_in every cycle, all states). On event: VALID_out <= 0, WORDS_out += 1; then if remaining!=0 and CNT_grant!=0 -> READ; else -> ARB if ENABLE_in else IDLE.
- Ack events outside WAIT_ACK are discarded (ack_q still tracks).
- ENABLE_in low only takes effect at burst end; current burst completes.
- Underflow guard: CNT_grant==0 mid-burst ends burst early; LAST_out of the prior word stays as captured (0).
- OVF_out[i] set on any cycle FULLi_in=1; cleared by CLR_in; set wins over simultaneous clear.
- CLR_in also zeroes WORDS_out; simultaneous ack increment is lost (counter = 0).
- RD0_out and RD1_out never high together; never high outside READ.

## Timing
- Reset (async): state IDLE, all RD low, DATA_out 0, VALID_out/CH_out/LAST_out/BUSY_out 0, OVF_out 0, WORDS_out 0, last_grant 1 (ch0 wins first), ack_q <= ACK_in value sampled on first clock after release (no spurious ack).
- Reset mid-burst: strobes and VALID drop immediately; no further reads.
- Latency IDLE->first word: IDLE(t), ARB(t+1), READ/RD high(t+2), CAPTURE(t+3), VALID_out high from t+4.
- Word-to-word: ack change sampled at edge a -> VALID low at a+1, RD high during cycle a+1, VALID high again at a+3.
- Max throughput 1 word per 3 cycles plus host ack latency.

## Test plan
- Single channel: CNT0=3, CNT1=0, BURST_LEN=8 -> three RD0 pulses, one per ack; CH_out=0, LAST_out=1 on third word; WORDS_out=3; back to IDLE.
- Round-robin: CNT0=CNT1=10, BURST_LEN=4 -> bursts ch0(4), ch1(4), ch0(4), ch1(4), ch0(2), ch1(2); RD0/RD1 never overlap.
- BURST_LEN=0 with CNT0=300 -> first burst exactly 256 words, LAST_out on word 256.
- Ack discipline: toggle ACK_in twice while IDLE, then one toggle per word -> no extra WORDS_out counts; VALID_out falls exactly 1 cycle after each toggle.
- ENABLE_in dropped mid-burst of 4 -> remaining words still delivered, then IDLE, no new ARB.
- FULL1_in pulse with CLR_in same cycle -> OVF_out=2'b10; async RESET_in mid-WAIT_ACK -> all outputs 0 in same cycle.
